pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial bit-pattern transmitter for the FSM lab: captures an 8-bit pattern from the switches and shifts it out MSB-first, one bit per clock, on a single `w` line, driving the stream into the four-in-a-row sequence detector (`w` input, `z` output). Supports single-pass and continuous-loop transmission. Optionally tracks the emitted stream and flags where a downstream detector must fire, giving a self-checking board demo.

## Interface
- `RUN_LEN`, default 4: number of consecutive equal bits that constitutes a detected run.
- `PAT_W`, default 8: pattern width; fixed by the switch map below.

- `KEY[0]`  input  1  clock, rising edge (manual pushbutton clock).
- `SW[0]`  input  1  reset: synchronous, active-low.
- `KEY[1]`  input  1  go, active-low (pressed = 0), sampled on the clock edge.
- `SW[8:1]`  input  8  pattern; SW[8] is sent first.
- `SW[9]`  input  1  loop: 1 = repeat continuously, 0 = single pass.
- `LEDR[0]`  output  1  `w`, serial data out, registered.
- `LEDR[3:1]`  output  3  current bit index `idx`, 7 down to 0.
- `LEDR[5:4]`  output  2  state: IDLE=00, SEND=01, DONE=10.
- `LEDR[6]`  output  1  done, high in DONE.
- `LEDR[7]`  output  1  tied 0.
- `LEDR[9:8]`  output  2  LEDR[9] = expected z (see Configuration); LEDR[8] tied 0.

## Operation
- Registers: `pat[7:0]`, `idx[2:0]`, `w`, state, `run` (saturating at RUN_LEN), `last`.
- IDLE: w=0, idx=0. If go is asserted at an edge: pat←SW[8:1], w←SW[8], idx←7, run←1, last←SW[8], →SEND.
- SEND, idx>0: idx←idx−1, w←pat[idx−1].
- SEND, idx=0, SW[9]=1: idx←7, w←pat[7] from captured pat, stay in SEND. The stream is continuous, and run tracking carries across the wrap.
- SEND, idx=0, SW[9]=0: →DONE, w←0, run←0.
- DONE: done=1, w=0. Returns to IDLE at the first edge where go is deasserted. This gives one pass per press.
- Go is ignored in SEND. SW[8:1] is read only on the IDLE→SEND edge. SW[9] is read live at each idx=0 edge.
- Run tracking: at each edge emitting a new bit b, if b==last then run←min(run+1, RUN_LEN), else run←1. last←b.
- Unused state encoding 11: next state is IDLE, w=0.

## Timing
- Reset value of every output is 0: w, idx, state, done, LEDR[9], and tied bits. pat, run and last also clear.
- Reset wins over all other inputs at that edge, including mid-SEND. At the next edge the block is in IDLE with w=0. A subsequent go restarts from the MSB.
- Latency: pattern bit SW[8−k] appears on w for the cycle following edge k+1, counted from the go edge (edge 1). Single pass: w is valid for exactly 8 cycles, then DONE.
- Expected z (LEDR[9]) is high in the same cycle that w shows the bit completing ≥RUN_LEN equal bits. A detector clocked by the same KEY[0] asserts its z one edge later.

## Configuration
- `PATTERN_TX_EXPECT_EN` defined: the run/last tracker is compiled in. LEDR[9] = (run == RUN_LEN) while in SEND, 0 otherwise.
- Not defined: no run/last registers are built. LEDR[9] is tied 0. All other behaviour is identical.

## Test plan
- SW[0]=0 for one edge mid-anything → all LEDR = 0, state IDLE.
- SW[8:1]=11110000, SW[9]=0, one go press → w = 1,1,1,1,0,0,0,0 on 8 consecutive cycles. LEDR[9] is high on cycles 4 and 8. Then DONE with LEDR[6]=1, held until KEY[1] is released, then IDLE.
- SW[8:1]=10101010, SW[9]=1 → w alternates for 24+ cycles with no DONE. LEDR[9] never asserts. idx wraps 0→7.
- SW[8:1]=11000011, SW[9]=1 → first pass: LEDR[9] high on the 6th bit. Second pass: LEDR[9] high on the 2nd bit (wrap run 1,1,1,1).
- Start a pass, assert SW[0]=0 after 3 bits → next cycle w=0 and IDLE. A new go emits from SW[8] again.
- Change SW[8:1] during SEND → emitted bits are unchanged. Clear SW[9] during a loop → the current pass completes, then DONE.

Source files
------------

// File: rtl/pattern_tx_if.sv
// Board-side signal bundle for pattern_tx: go key, pattern/loop switches and LEDs.
// The board drives through the master modport and the transmitter uses the slave modport.
interface pattern_tx_if;
  logic       i_key1;  // go, active-low (pressed = 0)
  logic [9:1] i_sw;    // [8:1] pattern (SW[8] sent first), [9] loop
  logic [9:0] o_ledr;

  modport master (output i_key1, output i_sw, input  o_ledr);
  modport slave  (input  i_key1, input  i_sw, output o_ledr);
endinterface

// File: rtl/pattern_tx.sv
// Serial bit-pattern transmitter: shifts an 8-bit switch pattern out MSB-first on w, single pass or looping.
// Define PATTERN_TX_EXPECT_EN to build the run tracker that drives the expected-z LED (LEDR[9]).
module pattern_tx #(
  parameter int RUN_LEN = 4,
  parameter int PAT_W   = 8
) (
  input  logic         clk,    // KEY[0], manual pushbutton clock
  input  logic         rst_n,  // SW[0], synchronous active-low
  pattern_tx_if.slave  bus
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t             r_state, w_nxt_state;
  logic [PAT_W-1:0]   r_pat,   w_nxt_pat;
  logic [IDX_W-1:0]   r_idx,   w_nxt_idx;
  logic               r_w,     w_nxt_w;
  logic [IDX_W-1:0]   w_idx_dec;
  logic               w_go;
  logic               w_loop;
  logic               w_exp_z;

  assign w_go      = ~bus.i_key1;
  assign w_loop    = bus.i_sw[9];
  assign w_idx_dec = r_idx - 1'b1;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous, so it sits inside the clocked block and no edge of rst_n appears in the sensitivity list.
    if (!rst_n) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_idx   <= '0;
      r_w     <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pat   <= w_nxt_pat;
      r_idx   <= w_nxt_idx;
      r_w     <= w_nxt_w;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pat   = r_pat;
    w_nxt_idx   = r_idx;
    w_nxt_w     = 1'b0;
    case (r_state)
      IDLE: begin
        w_nxt_idx = '0;
        if (w_go) begin
          w_nxt_state = SEND;
          w_nxt_pat   = bus.i_sw[PAT_W:1];
          w_nxt_w     = bus.i_sw[PAT_W];
          w_nxt_idx   = IDX_TOP;
        end
      end
      SEND: begin
        if (r_idx != '0) begin
          w_nxt_idx = w_idx_dec;
          w_nxt_w   = r_pat[w_idx_dec];
        end else if (w_loop) begin
          // Wrap replays the captured pattern; the switches are not re-read.
          w_nxt_idx = IDX_TOP;
          w_nxt_w   = r_pat[PAT_W-1];
        end else begin
          w_nxt_state = DONE;
        end
      end
      DONE: begin
        if (!w_go) w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

`ifdef PATTERN_TX_EXPECT_EN
  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

  logic [RUN_W-1:0] r_run,  w_nxt_run;
  logic             r_last, w_nxt_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run  <= '0;
      r_last <= 1'b0;
    end else begin
      r_run  <= w_nxt_run;
      r_last <= w_nxt_last;
    end
  end

  // Tracks the bit being emitted at this edge, so run lines up with w in the same cycle.
  always_comb begin
    w_nxt_run  = r_run;
    w_nxt_last = r_last;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_nxt_run  = RUN_W'(1);
          w_nxt_last = bus.i_sw[PAT_W];
        end
      end
      SEND: begin
        if (r_idx == '0 && !w_loop) begin
          w_nxt_run = '0;
        end else begin
          if (w_nxt_w == r_last)
            w_nxt_run = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
          else
            w_nxt_run = RUN_W'(1);
          w_nxt_last = w_nxt_w;
        end
      end
      default: ;
    endcase
  end

  assign w_exp_z = (r_state == SEND) && (r_run == RUN_MAX);
`else
  assign w_exp_z = 1'b0;
`endif

  assign bus.o_ledr = {w_exp_z, 1'b0, 1'b0, (r_state == DONE), r_state, r_idx, r_w};

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: full LEDR vector checked every cycle against hand-computed expectations.
// Expected-z checks follow PATTERN_TX_EXPECT_EN the same way the design does.
module tb_pattern_tx;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pattern_tx_if bus ();

  pattern_tx #(.RUN_LEN(4), .PAT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] LED_IDLE = 10'b00_0000_0000;
  localparam logic [9:0] LED_DONE = 10'b00_0110_0000;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks n SEND cycles; cycle k (absolute, 0-based) shows pat bit 7-(k%8). zmask bit k = expected z.
  task automatic expect_send(input string tag, input logic [7:0] pat, input int k0, input int n,
                             input logic [31:0] zmask);
    for (int k = k0; k < k0 + n; k++) begin
      int         j;
      logic [2:0] idx;
      logic       ez;
      tick();
      j   = 7 - (k % 8);
      idx = 3'(j);
`ifdef PATTERN_TX_EXPECT_EN
      ez = zmask[k];
`else
      ez = 1'b0;
`endif
      check($sformatf("%s_c%0d", tag, k + 1), bus.o_ledr,
            {ez, 1'b0, 1'b0, 1'b0, 2'b01, idx, pat[j]});
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus.i_key1 = 1'b0;
    bus.i_sw   = 9'h1FF;

    // Reset wins even with go pressed.
    tick();
    check("reset", bus.o_ledr, LED_IDLE);

    // Single pass 11110000, switches changed mid-pass, DONE held while go stays pressed.
    rst_n      = 1'b1;
    bus.i_sw   = {1'b0, 8'b1111_0000};
    bus.i_key1 = 1'b0;
    expect_send("single", 8'hF0, 0, 2, 32'h88);
    bus.i_sw   = {1'b0, 8'b0000_1111};
    expect_send("single", 8'hF0, 2, 6, 32'h88);
    tick();
    check("done1", bus.o_ledr, LED_DONE);
    tick();
    check("done_hold", bus.o_ledr, LED_DONE);
    bus.i_key1 = 1'b1;
    tick();
    check("idle_after_done", bus.o_ledr, LED_IDLE);

    // Loop 10101010: no z, idx wraps; clearing loop lets the current pass finish.
    bus.i_sw   = {1'b1, 8'b1010_1010};
    bus.i_key1 = 1'b0;
    expect_send("alt", 8'hAA, 0, 1, 32'h0);
    bus.i_key1 = 1'b1;
    expect_send("alt", 8'hAA, 1, 19, 32'h0);
    bus.i_sw[9] = 1'b0;
    expect_send("alt", 8'hAA, 20, 4, 32'h0);
    tick();
    check("alt_done", bus.o_ledr, LED_DONE);
    tick();
    check("alt_idle", bus.o_ledr, LED_IDLE);

    // Loop 11000011: z on bit 6 of pass 1, bits 2 and 6 of pass 2 (run carries across wrap).
    bus.i_sw   = {1'b1, 8'b1100_0011};
    bus.i_key1 = 1'b0;
    expect_send("wrap", 8'hC3, 0, 1, 32'h2220);
    bus.i_key1 = 1'b1;
    expect_send("wrap", 8'hC3, 1, 15, 32'h2220);
    rst_n = 1'b0;
    tick();
    check("reset_loop", bus.o_ledr, LED_IDLE);

    // Reset after 3 bits, then restart from the MSB with go still pressed.
    rst_n      = 1'b1;
    bus.i_sw   = {1'b0, 8'b0110_0101};
    bus.i_key1 = 1'b0;
    expect_send("pre_rst", 8'h65, 0, 3, 32'h0);
    rst_n = 1'b0;
    tick();
    check("reset_mid", bus.o_ledr, LED_IDLE);
    rst_n = 1'b1;
    expect_send("restart", 8'h65, 0, 3, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
